uart_cmd_responder: RTL and testbench



---
 rtl/uart_cmd_responder.sv | 263 ++++++++++++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder.sv
// Decodes host read/write packets arriving over the UART and turns them into memory bus accesses and response bytes.
// Define UART_CMD_CHECKSUM_EN to add a trailing checksum byte to write packets and to read responses.
module uart_cmd_responder #(
    parameter int         ADDR_W       = 24,
    parameter int         TIMEOUT_CLKS = 500000,
    parameter logic [7:0] ACK_BYTE     = 8'h06,
    parameter logic [7:0] NAK_BYTE     = 8'h15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    output logic              ena_tx,
    output logic [7:0]        tx_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              err_pulse
);

    localparam int              TMO_W    = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]      CMD_WR   = 8'h57;
    localparam logic [7:0]      CMD_RD   = 8'h52;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_WDATA,
        S_WR_MEM,
        S_RD_MEM,
        S_TX_LOAD,
        S_TX_HOLD,
        S_DONE
`ifdef UART_CMD_CHECKSUM_EN
        , S_CKSUM
`endif
    } state_t;

    state_t              state_q, state_d;
    logic                is_wr_q, is_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          abyte_q, abyte_d;
    logic [8:0]          count_q, count_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          txd_q, txd_d;
    logic                resp_q, resp_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                err_q, err_d;
    logic                in_pkt;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            abyte_q <= '0;
            count_q <= '0;
            wdata_q <= '0;
            txd_q   <= '0;
            resp_q  <= 1'b0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            abyte_q <= abyte_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            txd_q   <= txd_d;
            resp_q  <= resp_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`ifdef UART_CMD_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        abyte_d = abyte_q;
        count_d = count_q;
        wdata_d = wdata_q;
        txd_d   = txd_q;
        resp_d  = resp_q;
        tmo_d   = '0;
        err_d   = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
        sum_d   = sum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (rx_rdy) begin
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        is_wr_d = (rx_data == CMD_WR);
                        abyte_d = 2'd2;
                        state_d = S_ADDR;
`ifdef UART_CMD_CHECKSUM_EN
                        sum_d   = rx_data;
`endif
                    end else begin
                        txd_d   = NAK_BYTE;
                        resp_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_TX_LOAD;
                    end
                end
            end
            S_ADDR: begin
                if (rx_rdy) begin
                    // Shift MSB-first; bits beyond ADDR_W fall off the top.
                    addr_d  = ADDR_W'({addr_q, rx_data});
                    abyte_d = abyte_q - 2'd1;
`ifdef UART_CMD_CHECKSUM_EN
                    sum_d   = sum_q + rx_data;
`endif
                    if (abyte_q == 2'd0) begin
                        state_d = S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (rx_rdy) begin
                    count_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
`ifdef UART_CMD_CHECKSUM_EN
                    sum_d   = is_wr_q ? (sum_q + rx_data) : 8'h00;
`endif
                    state_d = is_wr_q ? S_WDATA : S_RD_MEM;
                end
            end
            S_WDATA: begin
                if (rx_rdy) begin
                    wdata_d = rx_data;
`ifdef UART_CMD_CHECKSUM_EN
                    sum_d   = sum_q + rx_data;
`endif
                    state_d = S_WR_MEM;
                end
            end
            S_WR_MEM: begin
                err_d = rx_rdy;
                if (mem_ack) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    count_d = count_q - 9'd1;
                    if (count_q == 9'd1) begin
`ifdef UART_CMD_CHECKSUM_EN
                        state_d = S_CKSUM;
`else
                        txd_d   = ACK_BYTE;
                        resp_d  = 1'b1;
                        state_d = S_TX_LOAD;
`endif
                    end else begin
                        state_d = S_WDATA;
                    end
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            S_CKSUM: begin
                if (rx_rdy) begin
                    resp_d  = 1'b1;
                    state_d = S_TX_LOAD;
                    if (rx_data == sum_q) begin
                        txd_d = ACK_BYTE;
                    end else begin
                        txd_d = NAK_BYTE;
                        err_d = 1'b1;
                    end
                end
            end
`endif
            S_RD_MEM: begin
                err_d = rx_rdy;
                if (mem_ack) begin
                    txd_d   = mem_rdata;
                    addr_d  = addr_q + ADDR_W'(1);
                    count_d = count_q - 9'd1;
`ifdef UART_CMD_CHECKSUM_EN
                    sum_d   = sum_q + mem_rdata;
`endif
                    state_d = S_TX_LOAD;
                end
            end
            S_TX_LOAD: begin
                err_d = rx_rdy;
                if (!tx_busy) begin
                    state_d = S_TX_HOLD;
                end
            end
            S_TX_HOLD: begin
                // tx_busy only rises after this clock, so the hold state covers that gap.
                err_d = rx_rdy;
                if (resp_q) begin
                    state_d = S_DONE;
                end else if (count_q != 9'd0) begin
                    state_d = S_RD_MEM;
                end else begin
`ifdef UART_CMD_CHECKSUM_EN
                    txd_d   = sum_q;
                    resp_d  = 1'b1;
                    state_d = S_TX_LOAD;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_DONE: begin
                err_d   = rx_rdy;
                resp_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (in_pkt) begin
            if (rx_rdy) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

`ifdef UART_CMD_CHECKSUM_EN
    assign in_pkt = (state_q == S_ADDR) || (state_q == S_LEN) ||
                    (state_q == S_WDATA) || (state_q == S_CKSUM);
`else
    assign in_pkt = (state_q == S_ADDR) || (state_q == S_LEN) ||
                    (state_q == S_WDATA);
`endif

    assign mem_req   = (state_q == S_WR_MEM) || (state_q == S_RD_MEM);
    assign mem_we    = (state_q == S_WR_MEM);
    assign ena_tx    = (state_q == S_TX_HOLD);
    assign tx_data   = txd_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign err_pulse = err_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder with a small memory responder and transceiver model.
// Checksum-specific expectations are enabled by UART_CMD_CHECKSUM_EN.
module tb_uart_cmd_responder;

    localparam int ADDR_W = 24;
    localparam int TMO    = 40;
    localparam int GAP    = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              tx_busy;
    logic              ena_tx;
    logic [7:0]        tx_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              busy;
    logic              err_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;

    logic [31:0] wr_log[$];
    logic [23:0] rd_log[$];
    logic [7:0]  tx_log[$];

    uart_cmd_responder #(
        .ADDR_W       (ADDR_W),
        .TIMEOUT_CLKS (TMO),
        .ACK_BYTE     (8'h06),
        .NAK_BYTE     (8'h15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .tx_busy   (tx_busy),
        .ena_tx    (ena_tx),
        .tx_data   (tx_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .err_pulse (err_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_model(input logic [23:0] a);
        case (a)
            24'h000010: return 8'h11;
            24'h000011: return 8'h22;
            24'h000012: return 8'h33;
            default:    return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] txq(input int i);
        if (i < tx_log.size()) return 32'(tx_log[i]);
        return 32'hBAD0_0000;
    endfunction

    function automatic logic [31:0] wrq(input int i);
        if (i < wr_log.size()) return wr_log[i];
        return 32'hBAD0_0000;
    endfunction

    function automatic logic [31:0] rdq(input int i);
        if (i < rd_log.size()) return 32'(rd_log[i]);
        return 32'hBAD0_0000;
    endfunction

    // Memory side: acknowledge every request on its second sampled clock.
    initial begin
        int w;
        w         = 0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!rst_n || !mem_req) begin
                w = 0;
            end else begin
                w++;
                if (w == 2) begin
                    w       = 0;
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        wr_log.push_back({mem_addr, mem_wdata});
                    end else begin
                        rd_log.push_back(mem_addr);
                        mem_rdata = mem_model(mem_addr);
                    end
                end
            end
        end
    end

    // Transceiver side: busy rises the clock after a load and stays up for 8 clocks.
    initial begin
        int cyc, last, hold;
        bit pend, saw;
        cyc     = 0;
        last    = -100;
        hold    = 0;
        pend    = 1'b0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            saw = 1'b0;
            if (ena_tx) begin
                check_eq("tx_busy_low_at_ena", 32'(tx_busy), 32'd0);
                check_eq("ena_not_adjacent", 32'((cyc - last) > 1), 32'd1);
                last = cyc;
                tx_log.push_back(tx_data);
                saw = 1'b1;
            end
            if (hold > 0) begin
                hold--;
                if (hold == 0) tx_busy = 1'b0;
            end
            if (pend) begin
                tx_busy = 1'b1;
                hold    = 8;
                pend    = 1'b0;
            end
            if (saw) pend = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (err_pulse) err_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_rdy  = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_rdy  = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
        tx_log.delete();
        err_cnt = 0;
    endtask

    task automatic report(input string name);
        $display("pkt %s: writes=%0d reads=%0d tx=%0d err=%0d",
                 name, wr_log.size(), rd_log.size(), tx_log.size(), err_cnt);
    endtask

    initial begin
        int          n, bad_a, bad_d;
        logic [23:0] ea;
        logic [7:0]  cks;

        rst_n   = 1'b0;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_ena_tx",    32'(ena_tx),    32'd0);
        check_eq("rst_tx_data",   32'(tx_data),   32'd0);
        check_eq("rst_mem_req",   32'(mem_req),   32'd0);
        check_eq("rst_mem_we",    32'(mem_we),    32'd0);
        check_eq("rst_mem_addr",  32'(mem_addr),  32'd0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check_eq("rst_busy",      32'(busy),      32'd0);
        check_eq("rst_err",       32'(err_pulse), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write two bytes at 0x000100.
        clear_logs();
        send_byte(8'h57, GAP); send_byte(8'h00, GAP); send_byte(8'h01, GAP);
        send_byte(8'h00, GAP); send_byte(8'h02, GAP); send_byte(8'hAA, GAP);
        send_byte(8'hBB, GAP);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'hBF, GAP);
`endif
        wait_idle("wr_idle");
        report("write");
        check_eq("wr_count", 32'(wr_log.size()), 32'd2);
        check_eq("wr_0", wrq(0), 32'h000100AA);
        check_eq("wr_1", wrq(1), 32'h000101BB);
        check_eq("wr_no_reads", 32'(rd_log.size()), 32'd0);
        check_eq("wr_tx_count", 32'(tx_log.size()), 32'd1);
        check_eq("wr_ack", txq(0), 32'h06);
        check_eq("wr_err", 32'(err_cnt), 32'd0);

        // Read three bytes at 0x000010.
        clear_logs();
        send_byte(8'h52, GAP); send_byte(8'h00, GAP); send_byte(8'h00, GAP);
        send_byte(8'h10, GAP); send_byte(8'h03, GAP);
        wait_idle("rd_idle");
        report("read");
        check_eq("rd_count", 32'(rd_log.size()), 32'd3);
        check_eq("rd_a0", rdq(0), 32'h10);
        check_eq("rd_a1", rdq(1), 32'h11);
        check_eq("rd_a2", rdq(2), 32'h12);
        check_eq("rd_tx0", txq(0), 32'h11);
        check_eq("rd_tx1", txq(1), 32'h22);
        check_eq("rd_tx2", txq(2), 32'h33);
`ifdef UART_CMD_CHECKSUM_EN
        check_eq("rd_tx_count", 32'(tx_log.size()), 32'd4);
        check_eq("rd_tx_sum", txq(3), 32'h66);
`else
        check_eq("rd_tx_count", 32'(tx_log.size()), 32'd3);
`endif
        check_eq("rd_no_writes", 32'(wr_log.size()), 32'd0);
        check_eq("rd_err", 32'(err_cnt), 32'd0);

        // Byte arriving while a read is on the bus is dropped.
        clear_logs();
        send_byte(8'h52, GAP); send_byte(8'h00, GAP); send_byte(8'h00, GAP);
        send_byte(8'h10, GAP); send_byte(8'h01, 0);
        send_byte(8'h99, 0);
        wait_idle("drop_idle");
        report("drop");
        check_eq("drop_err", 32'(err_cnt), 32'd1);
        check_eq("drop_reads", 32'(rd_log.size()), 32'd1);
        check_eq("drop_tx0", txq(0), 32'h11);
`ifdef UART_CMD_CHECKSUM_EN
        check_eq("drop_tx_count", 32'(tx_log.size()), 32'd2);
`else
        check_eq("drop_tx_count", 32'(tx_log.size()), 32'd1);
`endif

        // Unknown command byte.
        clear_logs();
        send_byte(8'h41, GAP);
        wait_idle("bad_idle");
        report("bad_cmd");
        check_eq("bad_tx_count", 32'(tx_log.size()), 32'd1);
        check_eq("bad_nak", txq(0), 32'h15);
        check_eq("bad_err", 32'(err_cnt), 32'd1);
        check_eq("bad_no_mem", 32'(wr_log.size() + rd_log.size()), 32'd0);

        // Abandoned packet times out, then a normal write follows.
        clear_logs();
        send_byte(8'h57, GAP);
        send_byte(8'h00, 0);
        n = 0;
        while (busy && n < TMO + 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("tmo_window", 32'(n >= TMO - 1 && n <= TMO + 1), 32'd1);
        check_eq("tmo_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        report("timeout");
        check_eq("tmo_err", 32'(err_cnt), 32'd1);
        check_eq("tmo_no_tx", 32'(tx_log.size()), 32'd0);
        check_eq("tmo_no_mem", 32'(wr_log.size() + rd_log.size()), 32'd0);
        clear_logs();
        send_byte(8'h57, GAP); send_byte(8'h00, GAP); send_byte(8'h00, GAP);
        send_byte(8'h20, GAP); send_byte(8'h01, GAP); send_byte(8'h5C, GAP);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'hD4, GAP);
`endif
        wait_idle("post_tmo_idle");
        report("post_timeout_write");
        check_eq("post_tmo_wr", wrq(0), 32'h0000205C);
        check_eq("post_tmo_ack", txq(0), 32'h06);
        check_eq("post_tmo_err", 32'(err_cnt), 32'd0);

        // LEN=0 read from the top of the address space wraps to zero.
        clear_logs();
        send_byte(8'h52, GAP); send_byte(8'hFF, GAP); send_byte(8'hFF, GAP);
        send_byte(8'hFF, GAP); send_byte(8'h00, GAP);
        wait_idle("wrap_idle");
        report("read_256_wrap");
        check_eq("wrap_reads", 32'(rd_log.size()), 32'd256);
        check_eq("wrap_a0",   rdq(0),   32'hFFFFFF);
        check_eq("wrap_a1",   rdq(1),   32'h000000);
        check_eq("wrap_a255", rdq(255), 32'h0000FE);
        bad_a = 0;
        bad_d = 0;
        cks   = 8'h00;
        ea    = 24'hFFFFFF;
        for (int i = 0; i < 256; i++) begin
            if (rdq(i) !== 32'(ea)) bad_a++;
            if (txq(i) !== 32'(mem_model(ea))) bad_d++;
            cks = cks + mem_model(ea);
            ea  = ea + 24'd1;
        end
        check_eq("wrap_addr_mismatches", 32'(bad_a), 32'd0);
        check_eq("wrap_data_mismatches", 32'(bad_d), 32'd0);
`ifdef UART_CMD_CHECKSUM_EN
        check_eq("wrap_tx_count", 32'(tx_log.size()), 32'd257);
        check_eq("wrap_tx_sum", txq(256), 32'(cks));
`else
        check_eq("wrap_tx_count", 32'(tx_log.size()), 32'd256);
`endif

        // Reset while a read request is outstanding.
        clear_logs();
        send_byte(8'h52, GAP); send_byte(8'h00, GAP); send_byte(8'h00, GAP);
        send_byte(8'h40, GAP); send_byte(8'h02, 0);
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("rstmid_req_seen", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_mem_req", 32'(mem_req), 32'd0);
        check_eq("rstmid_busy", 32'(busy), 32'd0);
        check_eq("rstmid_addr", 32'(mem_addr), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        report("reset_mid_read");
        check_eq("rstmid_after_req", 32'(mem_req), 32'd0);
        check_eq("rstmid_no_tx", 32'(tx_log.size()), 32'd0);

        clear_logs();
        send_byte(8'h52, GAP); send_byte(8'h00, GAP); send_byte(8'h00, GAP);
        send_byte(8'h11, GAP); send_byte(8'h01, GAP);
        wait_idle("recover_idle");
        report("read_after_reset");
        check_eq("recover_addr", rdq(0), 32'h11);
        check_eq("recover_tx", txq(0), 32'h22);

`ifdef UART_CMD_CHECKSUM_EN
        clear_logs();
        send_byte(8'h57, GAP); send_byte(8'h00, GAP); send_byte(8'h00, GAP);
        send_byte(8'h00, GAP); send_byte(8'h01, GAP); send_byte(8'h05, GAP);
        send_byte(8'h5D, GAP);
        wait_idle("cks_ok_idle");
        report("checksum_good");
        check_eq("cks_ok_wr", wrq(0), 32'h00000005);
        check_eq("cks_ok_ack", txq(0), 32'h06);
        check_eq("cks_ok_err", 32'(err_cnt), 32'd0);

        clear_logs();
        send_byte(8'h57, GAP); send_byte(8'h00, GAP); send_byte(8'h00, GAP);
        send_byte(8'h00, GAP); send_byte(8'h01, GAP); send_byte(8'h05, GAP);
        send_byte(8'h00, GAP);
        wait_idle("cks_bad_idle");
        report("checksum_bad");
        check_eq("cks_bad_wr", wrq(0), 32'h00000005);
        check_eq("cks_bad_nak", txq(0), 32'h15);
        check_eq("cks_bad_err", 32'(err_cnt), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
